// File: rtl/det_pkg.sv
// det_pkg: shared constants, loader FSM states and matrix RAM addressing for the determinant engine
package det_pkg;

    localparam int MAX_DIM   = 32;
    localparam int BURST_LEN = 4;
    localparam int RAM_AW    = 10;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

    function automatic logic [RAM_AW-1:0] rowcol2addr(input logic [4:0] row, input logic [4:0] col);
        return RAM_AW'(row) * RAM_AW'(MAX_DIM) + RAM_AW'(col);
    endfunction

endpackage

// File: rtl/matrix_loader_wr.sv
// matrix_loader_wr: response-side row/col tracking and registered RAM write port
module matrix_loader_wr
    import det_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [5:0]        n,
    input  logic [10:0]       total,
    input  logic              rdv,
    input  logic [31:0]       rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    output logic              last
);

    logic [4:0]        row_q, row_d, col_q, col_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic              acc, wrap;

    always_comb begin
        acc        = en && rdv;
        wrap       = {1'b0, col_q} == n - 6'd1;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = acc;
        if (clr) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (acc) begin
            ram_addr_d = rowcol2addr(row_q, col_q);
            ram_data_d = rdata;
            col_d      = wrap ? 5'd0 : col_q + 5'd1;
            row_d      = wrap ? row_q + 5'd1 : row_q;
            cnt_d      = cnt_q + 11'd1;
        end
        // looks ahead one beat so done can follow the final RAM write directly
        last = cnt_d == total;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: Avalon-MM burst reader copying an NxN matrix into the 32x32 matrix RAM
module matrix_loader
    import det_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [5:0]  dim,
    output logic        busy,
    output logic        done,
    output logic [29:0] address,
    output logic        read,
    output logic [2:0]  burstcount,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_we
);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [10:0] left_q, left_d, total_q, total_d;
    logic [5:0]  n_q, n_d, n_in;
    logic        done_q, done_d;
    logic        wr_last;
    logic        unused_base;

    assign unused_base = ^{base_addr[31:30], base_addr[1:0]};

    always_comb begin
        n_in       = dim > 6'(MAX_DIM) ? 6'(MAX_DIM) : dim;
        read       = state_q == REQ;
        busy       = state_q != IDLE;
        burstcount = state_q != REQ ? 3'd1 : left_q < 11'(BURST_LEN) ? left_q[2:0] : 3'(BURST_LEN);
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        total_d    = total_q;
        n_d        = n_q;
        done_d     = state_q == FIN;
        case (state_q)
            IDLE: if (start) begin
                n_d     = n_in;
                total_d = 11'(n_in) * 11'(n_in);
                left_d  = total_d;
                addr_d  = {base_addr[29:2], 2'b00};
                state_d = n_in == 6'd0 ? FIN : REQ;
            end
            REQ: if (!waitrequest) begin
                addr_d  = addr_q + {25'd0, burstcount, 2'b00};
                left_d  = left_q - 11'(burstcount);
                state_d = left_d == 11'd0 ? DRAIN : REQ;
            end
            DRAIN: if (wr_last) state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            total_q <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            total_q <= total_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    assign address = addr_q;
    assign done    = done_q;

    matrix_loader_wr u_wr (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == IDLE && start),
        .en       (state_q == REQ || state_q == DRAIN),
        .n        (n_q),
        .total    (total_q),
        .rdv      (readdatavalid),
        .rdata    (readdata),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .last     (wr_last)
    );

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: table-driven and randomized transfers checked against a memory/RAM reference model
module tb_matrix_loader;
    import det_pkg::*;

    logic        clk = 0, reset = 0, start = 0;
    logic [31:0] base_addr = 0;
    logic [5:0]  dim = 0;
    logic        busy, done, read, ram_we;
    logic [29:0] address;
    logic [2:0]  burstcount;
    logic        waitrequest = 0, readdatavalid = 0;
    logic [31:0] readdata = 0;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;

    matrix_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .dim(dim),
        .busy(busy), .done(done), .address(address), .read(read), .burstcount(burstcount),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] base;
        int dim, stall, gap, fstall, repulse, exp_words, exp_bursts;
    } vec_t;
    typedef struct {logic [9:0] a; logic [31:0] d; int t;} wr_t;

    int checks = 0, passed = 0;
    int stall_pct = 0, gap_max = 0, force_stall = 0, stray_n = 0, gap = 0, hold_err = 0;
    logic [29:0] beat_q[$];
    logic [29:0] ba_q[$];
    logic [2:0]  bc_q[$];
    wr_t         wq[$];
    int          rdv_t[$];
    int          done_t[$];

    function automatic logic [31:0] memword(input logic [29:0] a);
        return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Avalon memory slave: random stalls, per-beat gaps, optional stray beats
    initial forever begin
        @(posedge clk); #1;
        if (force_stall > 0 && read) begin
            waitrequest = 1;
            force_stall--;
        end else waitrequest = $urandom_range(99) < 32'(stall_pct);
        readdatavalid = 0;
        if (stray_n > 0) begin
            readdatavalid = 1;
            readdata = $urandom;
            stray_n--;
        end else if (gap > 0) gap--;
        else if (beat_q.size() > 0) begin
            readdatavalid = 1;
            readdata = memword(beat_q.pop_front());
            gap = int'($urandom_range(gap_max));
        end
    end

    logic        prev_stall = 0;
    logic [29:0] prev_a = 0;
    logic [2:0]  prev_bc = 0;
    initial forever begin
        @(negedge clk);
        if (ram_we) wq.push_back('{ram_addr, ram_data, cyc});
        if (readdatavalid) rdv_t.push_back(cyc);
        if (done) done_t.push_back(cyc);
        if (prev_stall && !(read && address == prev_a && burstcount == prev_bc)) hold_err++;
        if (read && !waitrequest) begin
            ba_q.push_back(address);
            bc_q.push_back(burstcount);
            for (int i = 0; i < int'(burstcount); i++) beat_q.push_back(address + 30'(4 * i));
        end
        prev_stall = read && waitrequest && reset;
        prev_a = address;
        prev_bc = burstcount;
    end

    task automatic clear_obs();
        wq.delete(); rdv_t.delete(); done_t.delete(); ba_q.delete(); bc_q.delete();
        hold_err = 0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, ".busy"}, busy, 0);
        chk({p, ".done"}, done, 0);
        chk({p, ".read"}, read, 0);
        chk({p, ".ram_we"}, ram_we, 0);
        chk({p, ".burstcount"}, burstcount, 1);
        chk({p, ".address"}, address, 0);
        chk({p, ".ram_addr"}, ram_addr, 0);
        chk({p, ".ram_data"}, ram_data, 0);
    endtask

    task automatic run_xfer(input vec_t v, input int id);
        int n, t, c0, berr, werr, lerr, rem, exp_done;
        logic [29:0] bw;
        string p;
        p = $sformatf("v%0d", id);
        n = v.dim > MAX_DIM ? MAX_DIM : v.dim;
        t = n * n;
        bw = {v.base[29:2], 2'b00};
        clear_obs();
        stall_pct = v.stall; gap_max = v.gap; force_stall = v.fstall; gap = 0;
        @(posedge clk); #1;
        start = 1; base_addr = v.base; dim = 6'(v.dim); c0 = cyc;
        @(posedge clk); #1;
        start = 0; base_addr = $urandom; dim = 6'($urandom);
        @(negedge clk);
        chk({p, ".busy1"}, busy, 1);
        chk({p, ".read1"}, read, n > 0);
        if (n > 0) chk({p, ".addr1"}, address, bw);
        while (done_t.size() == 0 && cyc - c0 < 20000) begin
            @(posedge clk); #1;
            start = v.repulse != 0 && cyc - c0 == v.repulse;
        end
        start = 0;
        chk({p, ".timeout"}, done_t.size() > 0, 1);
        repeat (4) @(negedge clk);
        chk({p, ".bursts"}, ba_q.size(), v.exp_bursts);
        berr = 0;
        for (int i = 0; i < ba_q.size(); i++) begin
            rem = t - 4 * i;
            if (rem <= 0 || ba_q[i] != bw + 30'(16 * i) || bc_q[i] != 3'(rem > 4 ? 4 : rem)) berr++;
        end
        chk({p, ".burst_content_errs"}, berr, 0);
        chk({p, ".words"}, wq.size(), v.exp_words);
        werr = 0;
        for (int i = 0; i < wq.size(); i++)
            if (i >= t || wq[i].a != 10'((i / n) * 32 + i % n) || wq[i].d != memword(bw + 30'(4 * i))) werr++;
        chk({p, ".word_content_errs"}, werr, 0);
        lerr = rdv_t.size() == wq.size() ? 0 : 1;
        for (int i = 0; i < wq.size() && i < rdv_t.size(); i++)
            if (wq[i].t != rdv_t[i] + 1) lerr++;
        chk({p, ".write_latency_errs"}, lerr, 0);
        chk({p, ".done_count"}, done_t.size(), 1);
        exp_done = n == 0 ? c0 + 2 : wq.size() > 0 ? wq[wq.size() - 1].t + 1 : -2;
        chk({p, ".done_cycle"}, done_t.size() > 0 ? done_t[0] : -1, exp_done);
        chk({p, ".hold_errs"}, hold_err, 0);
        chk({p, ".busy_end"}, busy, 0);
    endtask

    task automatic reset_test();
        int c0;
        clear_obs();
        stall_pct = 0; gap_max = 1; force_stall = 0; gap = 0;
        @(posedge clk); #1;
        start = 1; base_addr = 32'h0000_3000; dim = 6'd3; c0 = cyc;
        @(posedge clk); #1;
        start = 0;
        while (wq.size() < 3 && cyc - c0 < 200) begin
            @(posedge clk); #1;
        end
        chk("rst.words_before", wq.size(), 3);
        reset = 0;
        @(posedge clk); #1;
        reset = 1; wq.delete(); done_t.delete(); stray_n = 4;
        @(negedge clk);
        chk_reset_vals("rst.after");
        repeat (12) @(negedge clk);
        chk("rst.stray_writes", wq.size(), 0);
        chk("rst.stray_done", done_t.size(), 0);
        chk_reset_vals("rst.hold");
        beat_q.delete(); gap = 0; stray_n = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[12];
        int n;
        tbl[0] = '{32'h0000_1000, 3, 0, 0, 0, 0, 9, 3};
        tbl[1] = '{32'h0000_2000, 2, 0, 0, 5, 0, 4, 1};
        tbl[2] = '{32'hDEAD_BEE0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{32'hC000_3003, 1, 20, 1, 0, 0, 1, 1};
        tbl[4] = '{32'h0000_4000, 5, 30, 2, 0, 0, 25, 7};
        tbl[5] = '{32'h1234_5678, 4, 10, 1, 0, 5, 16, 4};
        tbl[6] = '{32'h0010_0000, 32, 40, 3, 0, 0, 1024, 256};
        tbl[7] = '{32'h3FFF_FFF0, 45, 0, 0, 0, 0, 1024, 256};
        for (int i = 8; i < 12; i++) begin
            n = int'($urandom_range(1, 40));
            tbl[i] = '{$urandom, n, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)), 0, 0, 0, 0};
            n = n > 32 ? 32 : n;
            tbl[i].exp_words = n * n;
            tbl[i].exp_bursts = (n * n + 3) / 4;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("init");
        @(posedge clk); #1;
        reset = 1;
        for (int i = 0; i < 12; i++) run_xfer(tbl[i], i);
        reset_test();
        run_xfer('{32'h0000_5000, 1, 0, 0, 0, 0, 1, 1}, 12);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
